// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, drives imem, buffers {pc, instr} toward decode
// Ports: clk, rst_n (async active-low); fetch_enable run/hold;
//   imem_addr/imem_data combinational imem read; redirect_valid/redirect_pc branch resolve;
//   if_valid/if_ready/if_instr/if_pc decode handshake; pc_oob, misalign_err status.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 16,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        pc_oob,
  output logic        misalign_err
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [29:0] WORDS = 30'(IMEM_WORDS);
  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;
  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   buf_pc [FIFO_DEPTH];
  logic [31:0]   buf_instr [FIFO_DEPTH];
  logic          redir, misaligned, flush, push, pop;
  assign imem_addr    = pc_q;
  assign pc_oob       = pc_q[31:2] >= WORDS;
  assign if_valid     = cnt_q != '0;
  // gate the head so unwritten storage never leaks out while empty
  assign if_instr     = if_valid ? buf_instr[rd_q] : '0;
  assign if_pc        = if_valid ? buf_pc[rd_q] : '0;
  assign misalign_err = state_q == ERR;
  // ERR holds the buffer flushed every cycle; redirects there are ignored
  always_comb begin
    redir      = redirect_valid && state_q != ERR;
    misaligned = redir && redirect_pc[1:0] != 2'b00;
    flush      = redir || state_q == ERR;
    pop        = if_valid && if_ready && !flush;
    push       = state_q == RUN && fetch_enable && !flush && !pc_oob && (cnt_q < FULL || pop);
    state_d    = state_q == ERR ? ERR : misaligned ? ERR : redir ? state_q : fetch_enable ? RUN : IDLE;
    pc_d       = redir && !misaligned ? redirect_pc : push ? pc_q + 32'd4 : pc_q;
    cnt_d      = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    rd_d       = flush ? '0 : pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
    wr_d       = flush ? '0 : push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  // imem_data is captured only on push, so X on idle cycles stays out of the buffer
  always_ff @(posedge clk)
    if (push) begin
      buf_pc[wr_q]    <= pc_q;
      buf_instr[wr_q] <= imem_data;
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench with a queue-based reference model
module tb_instruction_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int WORDS = 16;
  logic        clk, rst_n, fetch_enable, redirect_valid, if_ready;
  logic [31:0] imem_addr, imem_data, redirect_pc, if_instr, if_pc;
  logic        if_valid, pc_oob, misalign_err;
  logic [31:0] imem [WORDS];
  logic [63:0] sb [$];
  logic [31:0] m_pc;
  int          m_mode;
  int          n_tests = 0, n_fail = 0;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_WORDS(WORDS), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_enable(fetch_enable), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .pc_oob(pc_oob), .misalign_err(misalign_err));

  initial clk = 0;
  always #5 clk = ~clk;
  assign imem_data = imem_addr[31:2] < WORDS ? imem[imem_addr[5:2]] : 32'hDEAD_BEEF;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 error; sb mirrors the fetch buffer contents.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pc = RESET_PC;
      m_mode = 0;
      sb.delete();
    end else if (m_mode == 2) sb.delete();
    else if (redirect_valid) begin
      sb.delete();
      if (redirect_pc[1:0] != 2'b00) m_mode = 2;
      else m_pc = redirect_pc;
    end else begin
      if (m_mode == 1 && fetch_enable && m_pc / 4 < WORDS && sb.size() < 2) begin
        sb.push_back({m_pc, imem[m_pc[5:2]]});
        m_pc = m_pc + 4;
      end
      m_mode = fetch_enable ? 1 : 0;
    end

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk)
    if (rst_n) begin
      check("if_valid", 32'(if_valid), 32'(sb.size() != 0));
      check("imem_addr", imem_addr, m_pc);
      check("pc_oob", 32'(pc_oob), 32'(m_pc / 4 >= WORDS));
      check("misalign_err", 32'(misalign_err), 32'(m_mode == 2));
      if (if_valid && sb.size() != 0) begin
        check("if_pc", if_pc, sb[0][63:32]);
        check("if_instr", if_instr, sb[0][31:0]);
        if (if_ready && !redirect_valid && m_mode != 2) void'(sb.pop_front());
      end
    end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redir(input logic [31:0] t);
    redirect_valid = 1;
    redirect_pc = t;
    cyc(1);
    redirect_valid = 0;
  endtask

  task automatic reset_checks();
    check("rst if_valid", 32'(if_valid), 32'h0);
    check("rst imem_addr", imem_addr, RESET_PC);
    check("rst if_pc", if_pc, 32'h0);
    check("rst if_instr", if_instr, 32'h0);
    check("rst misalign_err", 32'(misalign_err), 32'h0);
  endtask

  initial begin
    for (int k = 0; k < WORDS; k++) imem[k] = 32'(k + 1);
    rst_n = 0;
    fetch_enable = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    if_ready = 0;
    cyc(2);
    reset_checks();
    rst_n = 1;
    fetch_enable = 1;
    if_ready = 1;
    cyc(6);
    if_ready = 0;
    cyc(5);
    if_ready = 1;
    cyc(4);
    if_ready = 0;
    cyc(3);
    redir(32'h20);
    if_ready = 1;
    cyc(4);
    redir(32'h30);
    cyc(8);
    if_ready = 0;
    cyc(2);
    if_ready = 1;
    cyc(2);
    redir(32'h0);
    cyc(4);
    for (int i = 0; i < 300; i++) begin
      fetch_enable = $urandom_range(0, 7) != 0;
      if_ready = $urandom_range(0, 2) != 0;
      if ($urandom_range(0, 3) == 0) imem[$urandom_range(0, WORDS - 1)] = $urandom;
      if ($urandom_range(0, 11) == 0) redir({$urandom_range(0, 19), 2'b00});
      else cyc(1);
    end
    fetch_enable = 1;
    if_ready = 1;
    cyc(3);
    @(posedge clk);
    #3 rst_n = 0;
    #1 reset_checks();
    cyc(2);
    rst_n = 1;
    cyc(6);
    if_ready = 0;
    cyc(3);
    redir(32'h22);
    if_ready = 1;
    cyc(3);
    redir(32'h10);
    cyc(3);
    rst_n = 0;
    #1 reset_checks();
    cyc(1);
    rst_n = 1;
    cyc(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
